// File: rtl/lmb_bram_dp_init.sv
// True-dual-port byte-writable BRAM for the ILMB (port A) / DLMB (port B) path.
// After reset, a fill engine writes C_INIT_VALUE to every word, and same-word collisions are counted.
module lmb_bram_dp_init #(
    parameter int                      C_MEMSIZE       = 'h8000,
    parameter int                      C_PORT_DWIDTH   = 32,
    parameter int                      C_PORT_AWIDTH   = 32,
    parameter int                      C_NUM_WE        = C_PORT_DWIDTH / 8,
    parameter int                      C_OUT_REG       = 0,
    parameter int                      C_INIT_ON_RESET = 1,
    parameter logic [C_PORT_DWIDTH-1:0] C_INIT_VALUE   = '0
) (
    input  logic                     BRAM_Clk,
    input  logic                     BRAM_Rst_N,
    input  logic                     BRAM_EN_A,
    input  logic [C_NUM_WE-1:0]      BRAM_WEN_A,
    input  logic [C_PORT_AWIDTH-1:0] BRAM_Addr_A,
    input  logic [C_PORT_DWIDTH-1:0] BRAM_Dout_A,
    output logic [C_PORT_DWIDTH-1:0] BRAM_Din_A,
    input  logic                     BRAM_EN_B,
    input  logic [C_NUM_WE-1:0]      BRAM_WEN_B,
    input  logic [C_PORT_AWIDTH-1:0] BRAM_Addr_B,
    input  logic [C_PORT_DWIDTH-1:0] BRAM_Dout_B,
    output logic [C_PORT_DWIDTH-1:0] BRAM_Din_B,
    output logic                     Init_Done,
    output logic                     Collision,
    output logic [15:0]              Collision_Count
);
    localparam int DEPTH = C_MEMSIZE / C_NUM_WE;
    localparam int IW    = $clog2(DEPTH);
    localparam int BW    = (C_NUM_WE > 1) ? $clog2(C_NUM_WE) : 0;
    localparam int DW    = C_PORT_DWIDTH;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   fill_cnt;
    logic [DW-1:0]   mem [DEPTH];

    logic [IW-1:0]       idx_a, idx_b;
    logic                acc_a, acc_b, same_word, coll;
    logic [C_NUM_WE-1:0] we_a, we_b, we_b_eff;
    logic [DW-1:0]       rd_a, rd_b, rd1_a, rd1_b;
    logic                coll_q;
    logic [15:0]         coll_cnt, cnt_d;
    logic                addr_unused;

    // Upper address bits alias onto the same words; byte-offset bits carry no word information.
    assign idx_a       = BRAM_Addr_A[BW +: IW];
    assign idx_b       = BRAM_Addr_B[BW +: IW];
    assign addr_unused = &{BRAM_Addr_A, BRAM_Addr_B};

    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            state_q  <= (C_INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            fill_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) fill_cnt <= fill_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && fill_cnt == IW'(DEPTH - 1)) state_d = ST_READY;
    end

    // Port A owns any byte both ports write; B keeps its remaining bytes.
    always_comb begin
        acc_a     = (state_q == ST_READY) && BRAM_EN_A;
        acc_b     = (state_q == ST_READY) && BRAM_EN_B;
        same_word = (idx_a == idx_b);
        we_a      = acc_a ? BRAM_WEN_A : '0;
        we_b      = acc_b ? BRAM_WEN_B : '0;
        we_b_eff  = (acc_a && same_word) ? (we_b & ~we_a) : we_b;
        coll      = acc_a && acc_b && same_word && ((|BRAM_WEN_A) || (|BRAM_WEN_B));
        rd_a      = mem[idx_a];
        rd_b      = mem[idx_b];
        for (int i = 0; i < C_NUM_WE; i++) begin
            if (we_a[i]) rd_a[DW-1-8*i -: 8] = BRAM_Dout_A[DW-1-8*i -: 8];
            if (we_b[i]) rd_b[DW-1-8*i -: 8] = BRAM_Dout_B[DW-1-8*i -: 8];
        end
    end

    always_ff @(posedge BRAM_Clk) begin
        if (state_q == ST_INIT) begin
            mem[fill_cnt] <= C_INIT_VALUE;
        end else begin
            for (int i = 0; i < C_NUM_WE; i++) begin
                if (we_a[i])     mem[idx_a][DW-1-8*i -: 8] <= BRAM_Dout_A[DW-1-8*i -: 8];
                if (we_b_eff[i]) mem[idx_b][DW-1-8*i -: 8] <= BRAM_Dout_B[DW-1-8*i -: 8];
            end
        end
    end

    always_comb begin
        cnt_d = coll_cnt;
        if (coll && coll_cnt != 16'hFFFF) cnt_d = coll_cnt + 16'd1;
    end

    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            rd1_a     <= '0;
            rd1_b     <= '0;
            coll_q    <= 1'b0;
            coll_cnt  <= '0;
            Init_Done <= 1'b0;
        end else begin
            if (acc_a) rd1_a <= rd_a;
            if (acc_b) rd1_b <= rd_b;
            coll_q    <= coll;
            coll_cnt  <= cnt_d;
            Init_Done <= (state_d == ST_READY);
        end
    end

    generate
        if (C_OUT_REG != 0) begin : g_oreg
            logic [DW-1:0] out_a, out_b;
            always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
                if (!BRAM_Rst_N) begin
                    out_a <= '0;
                    out_b <= '0;
                end else begin
                    out_a <= rd1_a;
                    out_b <= rd1_b;
                end
            end
            assign BRAM_Din_A = out_a;
            assign BRAM_Din_B = out_b;
        end else begin : g_noreg
            assign BRAM_Din_A = rd1_a;
            assign BRAM_Din_B = rd1_b;
        end
    endgenerate

    assign Collision       = coll_q;
    assign Collision_Count = coll_cnt;

endmodule

// File: tb/tb_lmb_bram_dp_init.sv
// Directed bench: two instances (1- and 2-cycle read latency) with shared stimulus, 16-word memory.
module tb_lmb_bram_dp_init;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic [3:0]  wen_a, wen_b;
    logic [31:0] addr_a, addr_b, wdata_a, wdata_b;

    logic [31:0] d0_din_a, d0_din_b, d1_din_a, d1_din_b;
    logic        d0_done, d1_done, d0_coll, d1_coll;
    logic [15:0] d0_cnt, d1_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc;

    always #5 clk = ~clk;

    lmb_bram_dp_init #(.C_MEMSIZE('h40), .C_OUT_REG(0), .C_INIT_VALUE(32'hDEADBEEF)) dut0 (
        .BRAM_Clk(clk), .BRAM_Rst_N(rst_n),
        .BRAM_EN_A(en_a), .BRAM_WEN_A(wen_a), .BRAM_Addr_A(addr_a), .BRAM_Dout_A(wdata_a), .BRAM_Din_A(d0_din_a),
        .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b), .BRAM_Dout_B(wdata_b), .BRAM_Din_B(d0_din_b),
        .Init_Done(d0_done), .Collision(d0_coll), .Collision_Count(d0_cnt)
    );

    lmb_bram_dp_init #(.C_MEMSIZE('h40), .C_OUT_REG(1), .C_INIT_VALUE(32'hDEADBEEF)) dut1 (
        .BRAM_Clk(clk), .BRAM_Rst_N(rst_n),
        .BRAM_EN_A(en_a), .BRAM_WEN_A(wen_a), .BRAM_Addr_A(addr_a), .BRAM_Dout_A(wdata_a), .BRAM_Din_A(d1_din_a),
        .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b), .BRAM_Dout_B(wdata_b), .BRAM_Din_B(d1_din_b),
        .Init_Done(d1_done), .Collision(d1_coll), .Collision_Count(d1_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // WEN bit i selects byte lane i counted from the MSB.
    task automatic drive_a(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] data);
        en_a = en; wen_a = wen; addr_a = addr; wdata_a = data;
    endtask

    task automatic drive_b(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] data);
        en_b = en; wen_b = wen; addr_b = addr; wdata_b = data;
    endtask

    task automatic idle();
        drive_a(1'b0, 4'h0, 32'h0, 32'h0);
        drive_b(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 8) check_eq("init_din_quiet", d0_din_a, 32'h0);
            if (d0_done) begin
                cycles = c;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_din_a", d0_din_a, 32'h0);
        check_eq("rst_done", {31'h0, d0_done}, 32'h0);
        check_eq("rst_coll", {31'h0, d0_coll}, 32'h0);
        check_eq("rst_cnt", {16'h0, d0_cnt}, 32'h0);
        repeat (2) tick();

        // Fill, with writes attempted on both ports throughout INIT
        rst_n = 1'b1;
        drive_a(1'b1, 4'hF, 32'd0, 32'h12345678);
        drive_b(1'b1, 4'hF, 32'd4, 32'h87654321);
        wait_init(cyc);
        idle();
        check_eq("fill_cycles", cyc, 32'd16);
        check_eq("fill_done_oreg", {31'h0, d1_done}, 32'h1);
        for (int k = 0; k < 16; k++) begin
            drive_a(1'b1, 4'h0, 32'(k * 4), 32'h0);
            tick();
            check_eq($sformatf("fill_word%0d", k), d0_din_a, 32'hDEADBEEF);
        end

        // Byte writes on port A, word 2
        drive_a(1'b1, 4'b1111, 32'd8, 32'h11223344);
        tick();
        check_eq("bw_full", d0_din_a, 32'h11223344);
        drive_a(1'b1, 4'b1010, 32'd8, 32'hAABBCCDD);
        tick();
        check_eq("bw_partial_wf", d0_din_a, 32'h11BB33DD);
        drive_a(1'b0, 4'h0, 32'd0, 32'h0);
        drive_b(1'b1, 4'h0, 32'd8, 32'h0);
        tick();
        check_eq("bw_portb", d0_din_b, 32'h11BB33DD);
        check_eq("bw_hold_a", d0_din_a, 32'h11BB33DD);
        drive_b(1'b1, 4'h0, 32'd8 + 32'd64, 32'h0);
        tick();
        check_eq("bw_alias", d0_din_b, 32'h11BB33DD);
        check_eq("bw_no_coll", {16'h0, d0_cnt}, 32'h0);

        // Write-write collision on word 1 (holds DEADBEEF)
        drive_a(1'b1, 4'b0011, 32'd4, 32'hAAAAAAAA);
        drive_b(1'b1, 4'b0110, 32'd4, 32'hBBBBBBBB);
        tick();
        check_eq("ww_din_a", d0_din_a, 32'hAAAABEEF);
        check_eq("ww_din_b", d0_din_b, 32'hDEBBBBEF);
        check_eq("ww_pulse", {31'h0, d0_coll}, 32'h1);
        check_eq("ww_cnt", {16'h0, d0_cnt}, 32'h1);
        drive_a(1'b1, 4'h0, 32'd4, 32'h0);
        drive_b(1'b0, 4'h0, 32'd0, 32'h0);
        tick();
        check_eq("ww_stored", d0_din_a, 32'hAAAABBEF);
        check_eq("ww_pulse_end", {31'h0, d0_coll}, 32'h0);
        check_eq("ww_cnt_hold", {16'h0, d0_cnt}, 32'h1);

        // Read-write collision on word 3
        drive_a(1'b1, 4'hF, 32'd12, 32'h0);
        tick();
        drive_a(1'b1, 4'h0, 32'd12, 32'h0);
        drive_b(1'b1, 4'hF, 32'd12, 32'h5);
        tick();
        check_eq("rw_old", d0_din_a, 32'h0);
        check_eq("rw_pulse", {31'h0, d0_coll}, 32'h1);
        check_eq("rw_cnt", {16'h0, d0_cnt}, 32'h2);
        drive_b(1'b0, 4'h0, 32'd0, 32'h0);
        tick();
        check_eq("rw_new", d0_din_a, 32'h5);

        // Back-to-back reads of words 0,1,2 on both ports
        drive_a(1'b1, 4'h0, 32'd0, 32'h0);
        drive_b(1'b1, 4'h0, 32'd0, 32'h0);
        tick();
        check_eq("lat1_w0", d0_din_a, 32'hDEADBEEF);
        check_eq("lat2_pre_a", d1_din_a, 32'h5);
        check_eq("lat2_pre_b", d1_din_b, 32'h5);
        check_eq("rr_no_coll", {16'h0, d0_cnt}, 32'h2);
        drive_a(1'b1, 4'h0, 32'd4, 32'h0);
        drive_b(1'b1, 4'h0, 32'd4, 32'h0);
        tick();
        check_eq("lat2_w0_a", d1_din_a, 32'hDEADBEEF);
        check_eq("lat2_w0_b", d1_din_b, 32'hDEADBEEF);
        drive_a(1'b1, 4'h0, 32'd8, 32'h0);
        drive_b(1'b1, 4'h0, 32'd8, 32'h0);
        tick();
        check_eq("lat2_w1_a", d1_din_a, 32'hAAAABBEF);
        check_eq("lat2_w1_b", d1_din_b, 32'hAAAABBEF);
        idle();
        tick();
        check_eq("lat2_w2_a", d1_din_a, 32'h11BB33DD);
        check_eq("lat2_w2_b", d1_din_b, 32'h11BB33DD);

        // Saturation: preload the counter, then collide once more
        force dut1.coll_cnt = 16'hFFFF;
        tick();
        release dut1.coll_cnt;
        #1;
        check_eq("sat_preload", {16'h0, d1_cnt}, 32'hFFFF);
        drive_a(1'b1, 4'hF, 32'd0, 32'h0);
        drive_b(1'b1, 4'h0, 32'd0, 32'h0);
        tick();
        check_eq("sat_cnt", {16'h0, d1_cnt}, 32'hFFFF);
        check_eq("sat_pulse", {31'h0, d1_coll}, 32'h1);
        check_eq("cnt_three", {16'h0, d0_cnt}, 32'h3);

        // Load non-zero outputs, clobber word 15, then reset mid-fill
        drive_a(1'b1, 4'hF, 32'd60, 32'h0);
        drive_b(1'b1, 4'h0, 32'd8, 32'h0);
        tick();
        drive_a(1'b1, 4'h0, 32'd4, 32'h0);
        drive_b(1'b0, 4'h0, 32'd0, 32'h0);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        check_eq("async_din_a", d0_din_a, 32'h0);
        check_eq("async_din_b", d0_din_b, 32'h0);
        check_eq("async_done", {31'h0, d0_done}, 32'h0);
        check_eq("async_cnt", {16'h0, d0_cnt}, 32'h0);
        check_eq("async_oreg_a", d1_din_a, 32'h0);
        check_eq("async_oreg_cnt", {16'h0, d1_cnt}, 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (7) tick();
        check_eq("midfill_not_done", {31'h0, d0_done}, 32'h0);
        rst_n = 1'b0;
        #1;
        check_eq("midfill_rst_done", {31'h0, d0_done}, 32'h0);
        tick();
        rst_n = 1'b1;
        wait_init(cyc);
        check_eq("refill_cycles", cyc, 32'd16);
        drive_a(1'b1, 4'h0, 32'd60, 32'h0);
        drive_b(1'b1, 4'h0, 32'd0, 32'h0);
        tick();
        check_eq("refill_w15", d0_din_a, 32'hDEADBEEF);
        check_eq("refill_w0", d0_din_b, 32'hDEADBEEF);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
